// File: rtl/frame_max_finder_if.sv
// Sample-in / result-out handshake bundle for frame_max_finder.
// Min-tracking outputs exist only when FRAME_MIN_TRACK_EN is defined.
interface frame_max_finder_if #(
  parameter int K  = 8,
  parameter int IW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [K-1:0]  out_max;
  logic [IW-1:0] out_idx;
`ifdef FRAME_MIN_TRACK_EN
  logic [K-1:0]  out_min;
  logic [IW-1:0] out_min_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx,
    output out_min, out_min_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx,
    input  out_min, out_min_idx
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx
  );
`endif
endinterface

// File: rtl/frame_max_finder.sv
// Per-frame max (and optional min, macro FRAME_MIN_TRACK_EN) finder.
// N samples in, one registered result out, held until accepted.
module frame_max_finder #(
  parameter int K  = 8,
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  frame_max_finder_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t        r_state;
  logic [IW-1:0] r_count;
  logic [K-1:0]  r_max;
  logic [IW-1:0] r_idx;
  logic          r_out_valid;
  logic [K-1:0]  r_out_max;
  logic [IW-1:0] r_out_idx;

  logic          w_acc;
  logic          w_first;
  logic          w_last;
  logic          w_hs;
  logic          w_gt;
  logic [K-1:0]  w_nmax;
  logic [IW-1:0] w_nidx;

  assign bus.in_ready  = (r_state == COLLECT);
  assign bus.out_valid = r_out_valid;
  assign bus.out_max   = r_out_max;
  assign bus.out_idx   = r_out_idx;

  always_comb begin
    w_acc   = bus.in_valid && (r_state == COLLECT);
    w_first = (r_count == '0);
    w_last  = (r_count == IW'(N - 1));
    w_hs    = r_out_valid && bus.out_ready;
    // strict compare keeps the earliest index on ties
    w_gt    = w_first || (bus.in_data > r_max);
    w_nmax  = w_gt ? bus.in_data : r_max;
    w_nidx  = w_gt ? r_count : r_idx;
  end

`ifdef FRAME_MIN_TRACK_EN
  logic [K-1:0]  r_min;
  logic [IW-1:0] r_min_idx;
  logic [K-1:0]  r_out_min;
  logic [IW-1:0] r_out_min_idx;
  logic          w_lt;
  logic [K-1:0]  w_nmin;
  logic [IW-1:0] w_nmin_idx;

  assign bus.out_min     = r_out_min;
  assign bus.out_min_idx = r_out_min_idx;

  always_comb begin
    w_lt       = w_first || (bus.in_data < r_min);
    w_nmin     = w_lt ? bus.in_data : r_min;
    w_nmin_idx = w_lt ? r_count : r_min_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min         <= '0;
      r_min_idx     <= '0;
      r_out_min     <= '0;
      r_out_min_idx <= '0;
    end else if (flush) begin
      r_min         <= '0;
      r_min_idx     <= '0;
      r_out_min     <= '0;
      r_out_min_idx <= '0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_acc) begin
            r_min     <= w_nmin;
            r_min_idx <= w_nmin_idx;
            if (w_last) begin
              r_out_min     <= w_nmin;
              r_out_min_idx <= w_nmin_idx;
            end
          end
        end
        HOLD: begin
          if (w_hs) begin
            r_out_min     <= '0;
            r_out_min_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= COLLECT;
      r_count     <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
    end else if (flush) begin
      r_state     <= COLLECT;
      r_count     <= '0;
      r_max       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_acc) begin
            r_max <= w_nmax;
            r_idx <= w_nidx;
            if (w_last) begin
              r_state     <= HOLD;
              r_count     <= '0;
              r_out_valid <= 1'b1;
              r_out_max   <= w_nmax;
              r_out_idx   <= w_nidx;
            end else begin
              r_count <= r_count + IW'(1);
            end
          end
        end
        HOLD: begin
          if (w_hs) begin
            r_state     <= COLLECT;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_max   <= '0;
            r_out_idx   <= '0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_max_finder.sv
// Directed bench for frame_max_finder (K=8, N=16).
// Inputs driven and outputs sampled on the falling edge.
module tb_frame_max_finder;

  localparam int K  = 8;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk;
  logic reset;
  logic flush;
  int   n_pass;
  int   n_total;

  logic [K-1:0] fr [N];

  frame_max_finder_if #(.K(K), .IW(IW)) bus ();

  frame_max_finder #(.K(K), .N(N), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_frame();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_max !== 8'h00 ||
        bus.out_idx !== 4'd0 || bus.in_ready !== 1'b1)
      $display("FAIL reset: valid=%b max=%h idx=%0d rdy=%b want 0 00 0 1",
               bus.out_valid, bus.out_max, bus.out_idx, bus.in_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ascending();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'd15 ||
        bus.out_idx !== 4'd15)
      $display("FAIL ascending: valid=%b max=%h idx=%0d want 1 0f 15",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
`ifdef FRAME_MIN_TRACK_EN
    n_total++;
    if (bus.out_min !== 8'd0 || bus.out_min_idx !== 4'd0)
      $display("FAIL ascending_min: min=%h idx=%0d want 00 0",
               bus.out_min, bus.out_min_idx);
    else n_pass++;
`endif
    n_total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL hold_rdy: in_ready=%b want 0", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_max !== 8'h00 ||
        bus.out_idx !== 4'd0 || bus.in_ready !== 1'b1)
      $display("FAIL after_hs: valid=%b max=%h idx=%0d rdy=%b want 0 00 0 1",
               bus.out_valid, bus.out_max, bus.out_idx, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < N; i++) fr[i] = 8'hA5;
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'hA5 ||
        bus.out_idx !== 4'd0)
      $display("FAIL tie: valid=%b max=%h idx=%0d want 1 a5 0",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
`ifdef FRAME_MIN_TRACK_EN
    n_total++;
    if (bus.out_min !== 8'hA5 || bus.out_min_idx !== 4'd0)
      $display("FAIL tie_min: min=%h idx=%0d want a5 0",
               bus.out_min, bus.out_min_idx);
    else n_pass++;
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) fr[i] = 8'h00;
    fr[3] = 8'hFF;
    send_frame();
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid !== 1'b1 || bus.out_max !== 8'hFF ||
          bus.out_idx !== 4'd3 || bus.in_ready !== 1'b0) bad++;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      @(negedge clk);
    end
    n_total++;
    if (bad != 0)
      $display("FAIL hold5: %0d bad cycles want 0 (max=%h idx=%0d)",
               bad, bus.out_max, bus.out_idx);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'hFF)
      $display("FAIL hold_end: valid=%b max=%h want 1 ff",
               bus.out_valid, bus.out_max);
    else n_pass++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_hs: valid=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    else n_pass++;
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    fr[2] = 8'h50;
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'h50 ||
        bus.out_idx !== 4'd2)
      $display("FAIL bp_next: valid=%b max=%h idx=%0d want 1 50 2",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush_midframe();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 1) ? 8'hF0 : 8'h10;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_state: valid=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    else n_pass++;
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    fr[9] = 8'h80;
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'h80 ||
        bus.out_idx !== 4'd9)
      $display("FAIL flush_frame: valid=%b max=%h idx=%0d want 1 80 9",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_async_reset_hold();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) fr[i] = 8'h22;
    fr[6] = 8'h77;
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'h77 ||
        bus.out_idx !== 4'd6)
      $display("FAIL pre_rst: valid=%b max=%h idx=%0d want 1 77 6",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_max !== 8'h00 ||
        bus.out_idx !== 4'd0)
      $display("FAIL async_rst: valid=%b max=%h idx=%0d want 0 00 0",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL rst_rel: rdy=%b valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    else n_pass++;
    for (int i = 0; i < N; i++) fr[i] = 8'h01;
    fr[0] = 8'h90;
    send_frame();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'h90 ||
        bus.out_idx !== 4'd0)
      $display("FAIL rst_next: valid=%b max=%h idx=%0d want 1 90 0",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush_last();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0;
      if (i == N - 1) flush = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_max !== 8'h00)
      $display("FAIL flush_last: valid=%b rdy=%b max=%h want 0 1 00",
               bus.out_valid, bus.in_ready, bus.out_max);
    else n_pass++;
    for (int i = 0; i < N; i++) fr[i] = 8'h03;
    fr[5] = 8'h44;
    for (int i = 0; i < N - 1; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL early_valid: valid=%b want 0 after 15", bus.out_valid);
    else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_data  = fr[N-1];
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_max !== 8'h44 ||
        bus.out_idx !== 4'd5)
      $display("FAIL post_flush: valid=%b max=%h idx=%0d want 1 44 5",
               bus.out_valid, bus.out_max, bus.out_idx);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ascending();
    test_all_equal();
    test_backpressure();
    test_flush_midframe();
    test_async_reset_hold();
    test_flush_last();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
